// File: rtl/cache_pkg.sv
// Shared types and sizing for the 4-line fully associative cache controller.
package cache_pkg;

  localparam int NUM_LINES    = 4;
  localparam int LINE_IDX_W   = 2;
  localparam int CACHE_ADDR_W = 8;
  localparam int CACHE_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    MEM_RD = 3'd2,
    MEM_WR = 3'd3,
    RESP   = 3'd4
  } state_t;

  typedef struct packed {
    logic                    valid;
    logic [CACHE_ADDR_W-1:0] tag;
    logic [CACHE_DATA_W-1:0] data;
  } cache_entry_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/tag_match4.sv
// Combinational 4-way tag compare; also reports the lowest invalid line for fills.
module tag_match4
  import cache_pkg::*;
#(
  parameter int ADDR_W = CACHE_ADDR_W
) (
  input  logic [NUM_LINES-1:0]             valid,
  input  logic [NUM_LINES-1:0][ADDR_W-1:0] tags,
  input  logic [ADDR_W-1:0]                addr,
  output logic                             match,
  output logic [LINE_IDX_W-1:0]            hit_idx,
  output logic                             any_invalid,
  output logic [LINE_IDX_W-1:0]            first_invalid_idx
);

  // Scan high-to-low so the lowest invalid index is the one left standing.
  always_comb begin
    match             = 1'b0;
    hit_idx           = '0;
    any_invalid       = 1'b0;
    first_invalid_idx = '0;
    for (int i = NUM_LINES - 1; i >= 0; i--) begin
      if (valid[i] && (tags[i] == addr)) begin
        match   = 1'b1;
        hit_idx = LINE_IDX_W'(i);
      end else begin
        hit_idx = hit_idx;
      end
      if (!valid[i]) begin
        any_invalid       = 1'b1;
        first_invalid_idx = LINE_IDX_W'(i);
      end else begin
        first_invalid_idx = first_invalid_idx;
      end
    end
  end

endmodule

// File: rtl/fa_cache_ctrl.sv
// Controller for a 4-line fully associative write-through cache (read-allocate).
// Optional CACHE_STATS_EN adds saturating hit/miss counters.
module fa_cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_W = CACHE_ADDR_W,
  parameter int DATA_W = CACHE_DATA_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic                  resp_hit,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  repl_access,
  output logic                  repl_hit,
  output logic [LINE_IDX_W-1:0] repl_line,
  input  logic [LINE_IDX_W-1:0] repl_lru,
  output logic                  mem_rd_valid,
  output logic [ADDR_W-1:0]     mem_rd_addr,
  input  logic                  mem_rd_ack,
  input  logic [DATA_W-1:0]     mem_rd_data,
  output logic                  mem_wr_valid,
  output logic [ADDR_W-1:0]     mem_wr_addr,
  output logic [DATA_W-1:0]     mem_wr_data,
`ifdef CACHE_STATS_EN
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count,
`endif
  input  logic                  mem_wr_ack
);

  state_t state_r, state_s;

  logic [ADDR_W-1:0]     addr_r;
  logic [DATA_W-1:0]     wdata_r;
  logic                  we_r;
  logic                  lookup_hit_r;
  logic [LINE_IDX_W-1:0] victim_r;
  logic                  fill_hit_r;
  cache_entry_t          lines_r [NUM_LINES];

  logic                  req_ready_r, resp_valid_r, resp_hit_r;
  logic [DATA_W-1:0]     resp_rdata_r;
  logic                  repl_access_r, repl_hit_r;
  logic [LINE_IDX_W-1:0] repl_line_r;
  logic                  mem_rd_valid_r, mem_wr_valid_r;

  logic [NUM_LINES-1:0]             valid_s;
  logic [NUM_LINES-1:0][ADDR_W-1:0] tags_s;
  logic                             match_s, any_inv_s;
  logic [LINE_IDX_W-1:0]            hit_idx_s, first_inv_s;
  logic                             accept_s, lookup_s, touch_s, rd_done_s, wr_done_s;

  assign accept_s  = req_valid && req_ready_r && (state_r == IDLE);
  assign lookup_s  = (state_r == LOOKUP);
  assign touch_s   = lookup_s && match_s;
  assign rd_done_s = (state_r == MEM_RD) && mem_rd_valid_r && mem_rd_ack;
  assign wr_done_s = (state_r == MEM_WR) && mem_wr_valid_r && mem_wr_ack;

  // Flatten the line array into the compare unit's inputs.
  always_comb begin
    valid_s = '0;
    tags_s  = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      valid_s[i] = lines_r[i].valid;
      tags_s[i]  = lines_r[i].tag;
    end
  end

  tag_match4 #(.ADDR_W(ADDR_W)) u_match (
    .valid             (valid_s),
    .tags              (tags_s),
    .addr              (addr_r),
    .match             (match_s),
    .hit_idx           (hit_idx_s),
    .any_invalid       (any_inv_s),
    .first_invalid_idx (first_inv_s)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (accept_s) state_s = LOOKUP; else state_s = IDLE;
      LOOKUP:  if (we_r) state_s = MEM_WR; else if (match_s) state_s = RESP; else state_s = MEM_RD;
      MEM_RD:  if (rd_done_s) state_s = RESP; else state_s = MEM_RD;
      MEM_WR:  if (wr_done_s) state_s = RESP; else state_s = MEM_WR;
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Request capture and lookup bookkeeping; victim is frozen at lookup time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_r       <= '0;
      wdata_r      <= '0;
      we_r         <= 1'b0;
      lookup_hit_r <= 1'b0;
      victim_r     <= '0;
      fill_hit_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
        we_r    <= req_we;
      end
      if (lookup_s) begin
        lookup_hit_r <= match_s;
        victim_r     <= any_inv_s ? first_inv_s : repl_lru;
        fill_hit_r   <= any_inv_s;
      end
    end
  end

  // Line storage: write hits update data in place, read misses fill the victim.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LINES; i++) lines_r[i] <= '0;
    end else if (touch_s && we_r) begin
      lines_r[hit_idx_s].data <= wdata_r;
    end else if (rd_done_s) begin
      lines_r[victim_r] <= '{valid: 1'b1, tag: addr_r, data: mem_rd_data};
    end
  end

  // Registered interface outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_ready_r    <= 1'b0;
      resp_valid_r   <= 1'b0;
      resp_hit_r     <= 1'b0;
      resp_rdata_r   <= '0;
      repl_access_r  <= 1'b0;
      repl_hit_r     <= 1'b0;
      repl_line_r    <= '0;
      mem_rd_valid_r <= 1'b0;
      mem_wr_valid_r <= 1'b0;
    end else begin
      req_ready_r    <= (state_s == IDLE);
      resp_valid_r   <= (state_s == RESP);
      resp_hit_r     <= (state_s == RESP) && (lookup_s ? match_s : lookup_hit_r);
      mem_rd_valid_r <= (state_s == MEM_RD);
      mem_wr_valid_r <= (state_s == MEM_WR);
      repl_access_r  <= touch_s || rd_done_s;
      if (touch_s) begin
        repl_hit_r  <= 1'b1;
        repl_line_r <= hit_idx_s;
      end else if (rd_done_s) begin
        repl_hit_r  <= fill_hit_r;
        repl_line_r <= victim_r;
      end
      if (touch_s && !we_r) resp_rdata_r <= lines_r[hit_idx_s].data;
      else if (rd_done_s)   resp_rdata_r <= mem_rd_data;
      else if (wr_done_s)   resp_rdata_r <= '0;
    end
  end

  assign req_ready    = req_ready_r;
  assign resp_valid   = resp_valid_r;
  assign resp_hit     = resp_hit_r;
  assign resp_rdata   = resp_rdata_r;
  assign repl_access  = repl_access_r;
  assign repl_hit     = repl_hit_r;
  assign repl_line    = repl_line_r;
  assign mem_rd_valid = mem_rd_valid_r;
  assign mem_rd_addr  = addr_r;
  assign mem_wr_valid = mem_wr_valid_r;
  assign mem_wr_addr  = addr_r;
  assign mem_wr_data  = wdata_r;

`ifdef CACHE_STATS_EN
  logic [15:0] hit_cnt_r, miss_cnt_r;

  // Saturating lookup statistics, reads and writes alike.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt_r  <= 16'd0;
      miss_cnt_r <= 16'd0;
    end else if (lookup_s) begin
      if (match_s) hit_cnt_r  <= sat_inc16(hit_cnt_r);
      else         miss_cnt_r <= sat_inc16(miss_cnt_r);
    end
  end

  assign hit_count  = hit_cnt_r;
  assign miss_count = miss_cnt_r;
`endif

endmodule

// File: tb/tb_fa_cache_ctrl.sv
// Directed self-checking bench for fa_cache_ctrl; stats checks compile in with CACHE_STATS_EN.
module tb_fa_cache_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0, req_we = 1'b0;
  logic [7:0] req_addr = 8'h00, req_wdata = 8'h00;
  logic       req_ready, resp_valid, resp_hit;
  logic [7:0] resp_rdata;
  logic       repl_access, repl_hit;
  logic [1:0] repl_line;
  logic [1:0] repl_lru = 2'd0;
  logic       mem_rd_valid, mem_rd_ack = 1'b0;
  logic [7:0] mem_rd_addr, mem_rd_data = 8'h00;
  logic       mem_wr_valid, mem_wr_ack = 1'b0;
  logic [7:0] mem_wr_addr, mem_wr_data;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Observations from the most recent transaction.
  logic       o_hit, o_rhit, o_saw_rd, o_saw_wr, o_done;
  logic [7:0] o_rdata, o_wa, o_wd, o_rd_addr;
  logic [1:0] o_rline;
  int         o_acc, o_lat;

  always #5 clk = ~clk;

  fa_cache_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_hit     (resp_hit),
    .resp_rdata   (resp_rdata),
    .repl_access  (repl_access),
    .repl_hit     (repl_hit),
    .repl_line    (repl_line),
    .repl_lru     (repl_lru),
    .mem_rd_valid (mem_rd_valid),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_ack   (mem_rd_ack),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_valid (mem_wr_valid),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
`ifdef CACHE_STATS_EN
    .hit_count    (hit_count),
    .miss_count   (miss_count),
`endif
    .mem_wr_ack   (mem_wr_ack)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One CPU transaction with a memory model that acks reads after `lat` valid cycles.
  task automatic do_req(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                        input int lat, input logic [7:0] rdata);
    int n;
    int rd_wait;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("req_ready", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0;
    n = 1; rd_wait = 0;
    o_done = 1'b0; o_acc = 0; o_saw_rd = 1'b0; o_saw_wr = 1'b0;
    o_rhit = 1'b0; o_rline = 2'd0; o_wa = 8'h00; o_wd = 8'h00; o_rd_addr = 8'h00;
    while (!o_done && n <= 40) begin
      if (repl_access) begin o_acc++; o_rhit = repl_hit; o_rline = repl_line; end
      mem_rd_ack = 1'b0; mem_wr_ack = 1'b0;
      if (mem_rd_valid) begin
        o_saw_rd = 1'b1; o_rd_addr = mem_rd_addr; rd_wait++;
        if (rd_wait == lat) begin mem_rd_ack = 1'b1; mem_rd_data = rdata; end
      end
      if (mem_wr_valid) begin
        o_saw_wr = 1'b1; o_wa = mem_wr_addr; o_wd = mem_wr_data; mem_wr_ack = 1'b1;
      end
      if (resp_valid) begin
        o_done = 1'b1; o_hit = resp_hit; o_rdata = resp_rdata; o_lat = n;
      end else begin
        @(negedge clk); n++;
      end
    end
    mem_rd_ack = 1'b0; mem_wr_ack = 1'b0;
    chk("resp_seen", o_done, 1);
    @(negedge clk);
    chk("resp_one_cycle", resp_valid, 0);
  endtask

  task automatic rd_miss(input string tag, input logic [7:0] addr, input logic [7:0] data,
                         input logic exp_rhit, input logic [1:0] exp_line);
    do_req(1'b0, addr, 8'h00, 2, data);
    chk({tag, "_hit"}, o_hit, 0);
    chk({tag, "_rdata"}, o_rdata, data);
    chk({tag, "_rd_addr"}, o_rd_addr, addr);
    chk({tag, "_acc"}, o_acc, 1);
    chk({tag, "_repl_hit"}, o_rhit, exp_rhit);
    chk({tag, "_repl_line"}, o_rline, exp_line);
  endtask

  task automatic rd_hit(input string tag, input logic [7:0] addr, input logic [7:0] data,
                        input logic [1:0] exp_line);
    do_req(1'b0, addr, 8'h00, 2, 8'h00);
    chk({tag, "_hit"}, o_hit, 1);
    chk({tag, "_rdata"}, o_rdata, data);
    chk({tag, "_lat"}, o_lat, 2);
    chk({tag, "_no_mem"}, o_saw_rd, 0);
    chk({tag, "_acc"}, o_acc, 1);
    chk({tag, "_repl_line"}, o_rline, exp_line);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_rd_valid", mem_rd_valid, 0);
    chk("rst_repl_access", repl_access, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);

    // First read misses, fills lowest invalid line 0 after a 3-cycle memory latency.
    do_req(1'b0, 8'h10, 8'h00, 3, 8'hA5);
    chk("miss10_hit", o_hit, 0);
    chk("miss10_rdata", o_rdata, 8'hA5);
    chk("miss10_repl_hit", o_rhit, 1);
    chk("miss10_repl_line", o_rline, 0);
    rd_hit("hit10", 8'h10, 8'hA5, 2'd0);

    rd_miss("fill20", 8'h20, 8'h21, 1'b1, 2'd1);
    rd_miss("fill30", 8'h30, 8'h31, 1'b1, 2'd2);
    rd_miss("fill40", 8'h40, 8'h41, 1'b1, 2'd3);

    // Full cache: victim comes from the replacement unit.
    repl_lru = 2'd2;
    rd_miss("evict50", 8'h50, 8'h51, 1'b0, 2'd2);
    rd_hit("hit50", 8'h50, 8'h51, 2'd2);
    rd_miss("miss30", 8'h30, 8'h33, 1'b0, 2'd2);

    // Write hit: in-place update plus write-through.
    do_req(1'b1, 8'h20, 8'h3C, 2, 8'h00);
    chk("wrhit_hit", o_hit, 1);
    chk("wrhit_acc", o_acc, 1);
    chk("wrhit_repl_line", o_rline, 1);
    chk("wrhit_mem_addr", o_wa, 8'h20);
    chk("wrhit_mem_data", o_wd, 8'h3C);
    chk("wrhit_rdata", o_rdata, 0);
    chk("wrhit_no_rd", o_saw_rd, 0);
    rd_hit("rd20", 8'h20, 8'h3C, 2'd1);

    // Write miss: memory write only, no allocation, no replacement report.
    do_req(1'b1, 8'h99, 8'h77, 2, 8'h00);
    chk("wrmiss_hit", o_hit, 0);
    chk("wrmiss_acc", o_acc, 0);
    chk("wrmiss_wr", o_saw_wr, 1);
    chk("wrmiss_mem_addr", o_wa, 8'h99);
    chk("wrmiss_mem_data", o_wd, 8'h77);
    repl_lru = 2'd3;
    rd_miss("rd99", 8'h99, 8'h9A, 1'b0, 2'd3);

    // Reset in the middle of a read miss.
    req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h60;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!mem_rd_valid && n < 10) begin @(negedge clk); n++; end
    chk("midmiss_rd_valid", mem_rd_valid, 1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("midmiss_rd_drop", mem_rd_valid, 0);
    chk("midmiss_ready_low", req_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midmiss_ready", req_ready, 1);

    rd_miss("after_rst10", 8'h10, 8'hB6, 1'b1, 2'd0);
    rd_hit("h1", 8'h10, 8'hB6, 2'd0);
    rd_hit("h2", 8'h10, 8'hB6, 2'd0);
    rd_hit("h3", 8'h10, 8'hB6, 2'd0);
    rd_miss("after_rst20", 8'h20, 8'hC7, 1'b1, 2'd1);
`ifdef CACHE_STATS_EN
    chk("hit_count", hit_count, 3);
    chk("miss_count", miss_count, 2);
    force dut.hit_cnt_r = 16'hFFFF;
    @(negedge clk);
    release dut.hit_cnt_r;
    rd_hit("sat", 8'h10, 8'hB6, 2'd0);
    chk("hit_count_sat", hit_count, 16'hFFFF);
    chk("miss_count_hold", miss_count, 2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fa_cache_ctrl.md
Name: fa_cache_ctrl

Overview:
- Initiator-side controller for a 4-line fully associative, one-word-per-line, write-through cache.
- Accepts CPU requests and performs the tag lookup.
- On a hit or fill, issues the access report (hit flag + line index) that the LRU counter replacement unit consumes; takes that unit's victim line back.
- Handles read misses by fetching from memory and filling the victim line. Sits between the CPU port and the memory port.

Parameters:
ADDR_W, 8, address width; the full address is the tag.
DATA_W, 8, data word width.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req_valid  in  1  CPU request valid
req_ready  out  1  controller can accept a request
req_we  in  1  1 = write, 0 = read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
resp_valid  out  1  one-cycle response strobe
resp_hit  out  1  the request hit
resp_rdata  out  DATA_W  read data, valid with resp_valid
repl_access  out  1  one-cycle access strobe to the replacement unit
repl_hit  out  1  1 = line index given, 0 = replacement unit uses its own LRU line
repl_line  out  2  accessed line index
repl_lru  in  2  current LRU victim from the replacement unit
mem_rd_valid  out  1  memory read request, held until ack
mem_rd_addr  out  ADDR_W  memory read address
mem_rd_ack  in  1  read data valid / request complete
mem_rd_data  in  DATA_W  memory read data
mem_wr_valid  out  1  memory write request, held until ack
mem_wr_addr  out  ADDR_W  memory write address
mem_wr_data  out  DATA_W  memory write data
mem_wr_ack  in  1  write complete

Behaviour:
- Storage: 4 entries of {valid, tag[ADDR_W], data[DATA_W]}.
- Reset (reset=0, async): all valid bits 0, FSM to IDLE, every output 0. Tags and data are don't-care.
- req_ready=1 only in IDLE. A request is accepted when req_valid & req_ready; addr, we and wdata are registered.
- FSM states: IDLE, LOOKUP, MEM_RD, MEM_WR, RESP.
- IDLE -> LOOKUP on acceptance.
- LOOKUP: compare the registered addr against all 4 valid tags. Exactly one match is possible. hit_idx = matching index.
  - Read hit: resp_rdata = data[hit_idx]; pulse repl_access, repl_hit=1, repl_line=hit_idx; go to RESP. Total latency is 2 cycles from acceptance to resp_valid.
  - Write hit: update data[hit_idx]; pulse repl_access with repl_hit=1, repl_line=hit_idx; go to MEM_WR.
  - Write miss: no allocate, no repl_access; go to MEM_WR.
  - Read miss: choose victim.
    - If any entry is invalid, victim = lowest invalid index; fill reports repl_hit=1, repl_line=victim.
    - Otherwise victim = repl_lru sampled this cycle; fill reports repl_hit=0, repl_line=victim.
    - Go to MEM_RD.
- MEM_RD: mem_rd_valid=1 with mem_rd_addr=addr, held until mem_rd_ack.
  - On ack: write the entry {1, addr, mem_rd_data} at victim; resp_rdata = mem_rd_data; pulse repl_access per the rule above; go to RESP.
  - If ack arrives in the same cycle MEM_RD is entered, it is ignored; ack is sampled only while mem_rd_valid=1.
- MEM_WR: mem_wr_valid=1, addr and wdata held until mem_wr_ack; then go to RESP.
- RESP: resp_valid=1 for one cycle, resp_hit = lookup result; then return to IDLE.
- repl_access is high for exactly one cycle per line touch; never on a write miss.
- repl_hit and repl_line hold their last values otherwise.
- resp_rdata holds until the next response. For writes it is 0.
- Reset asserted mid-miss: request dropped, mem_*_valid deasserted immediately, all lines invalidated.
- req_valid while busy: not accepted; the requester holds the request.

Optional Feature:
CACHE_STATS_EN
- Defined: adds outputs hit_count[15:0] and miss_count[15:0].
  - Each increments on the LOOKUP result; each saturates at 16'hFFFF.
  - Both cleared by reset.
- Undefined: these ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cache_pkg:
  - state enum (IDLE, LOOKUP, MEM_RD, MEM_WR, RESP)
  - NUM_LINES=4, LINE_IDX_W=2
  - cache entry struct {valid, tag, data}
- Sub-module tag_match4: combinational 4-way tag compare.
  - Inputs: valid bits, tags, addr.
  - Outputs: match, hit_idx, any_invalid, first_invalid_idx.

Test Plan:
- After reset, read 0x10 with memory returning 0xA5 after 3 cycles -> resp_hit=0, rdata=0xA5; line 0 filled; repl_access with repl_hit=1, line=0.
- Read 0x10 again -> resp_valid 2 cycles after acceptance, resp_hit=1, rdata=0xA5, repl_line=0; no mem_rd_valid.
- Fill 0x10, 0x20, 0x30, 0x40 (lines 0-3); drive repl_lru=2; read 0x50 -> line 2 replaced with tag 0x50 and repl_hit=0; later read 0x30 misses.
- Write 0x20 with 0x3C on a hit -> data updated, mem_wr to 0x20/0x3C; read 0x20 returns 0x3C. Write 0x99 on a miss -> mem write only, no repl_access, no allocation.
- Assert reset while in MEM_RD -> mem_rd_valid drops asynchronously, req_ready=1 after release; read 0x10 misses.
- With CACHE_STATS_EN: 3 hits and 2 misses -> hit_count=3, miss_count=2; counter preloaded to 0xFFFF stays 0xFFFF on the next hit.
